key_sched_ctrl: RTL and testbench

Sequential AES round-key scheduler. It expands a 128/192/256-bit cipher key into all NR+1 round keys, producing one 32-bit word per clock, and holds them in an internal key store. A registered read port serves round keys by index to the round datapath. It sits between key load and the cipher/decipher round sequencers, replacing the elaboration-time expansion with a run-time, restartable one.

---
 rtl/key_sched_ctrl.sv | 162 ++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: sequential AES key expansion, one 32-bit word per clock,
// into an internal key store with a registered 128-bit round-key read port.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; key store holds last schedule if keys_ready
// EXPAND | computing and writing w[i], i = NK .. 4*(NR+1)-1
// DONE   | one-cycle done pulse; a start here begins a new expansion
module key_sched_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*NK-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic              keys_ready,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk_out,
    output logic              rk_valid
);

    localparam int         WORDS    = 4 * (NR + 1);
    localparam logic [5:0] LAST_I   = 6'(WORDS - 1);
    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [2:0] POS_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  i;
    // pos tracks i % NK and rcon tracks Rcon(i/NK), so no divider is needed
    logic [2:0]  pos;
    logic [7:0]  rcon;
    logic [31:0] w [WORDS];

    logic        capture;
    logic        expand_we;
    logic [5:0]  i_prev;
    logic [5:0]  i_back;
    logic [31:0] prev_word;
    logic [31:0] temp;
    logic [31:0] next_word;
    logic [5:0]  rd_base;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    assign capture   = !rst && start && (state == IDLE || state == DONE);
    assign expand_we = !rst && (state == EXPAND);
    assign i_prev    = i - 6'd1;
    assign i_back    = i - NK_W;
    assign prev_word = w[i_prev];

    // Next schedule word: RotWord/SubWord/Rcon at the start of each key-length group
    always_comb begin
        if (pos == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        end else if (NK == 8 && pos == 3'd4) begin
            temp = sub_word(prev_word);
        end else begin
            temp = prev_word;
        end
        next_word = w[i_back] ^ temp;
    end

    // Control FSM: sequencing, word counter, Rcon and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i          <= 6'd0;
            pos        <= 3'd0;
            rcon       <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        i          <= NK_W;
                        pos        <= 3'd0;
                        rcon       <= 8'h01;
                        keys_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXPAND: begin
                    i <= i + 6'd1;
                    if (pos == POS_LAST) pos <= 3'd0;
                    else                 pos <= pos + 3'd1;
                    if (pos == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (i == LAST_I) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_ready <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Key store: capture the cipher key, then one expanded word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int j = 0; j < NK; j++) begin
                w[j] <= key_in[32*(NK-1-j) +: 32];
            end
        end else if (expand_we) begin
            w[i] <= next_word;
        end
    end

    // Base index clamped so out-of-range rk_idx never addresses past the store
    assign rd_base = (rk_idx > NR_IDX) ? 6'd0 : {rk_idx, 2'b00};

    // Registered read port with validity flag aligned to rk_out
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out   <= 128'h0;
            rk_valid <= 1'b0;
        end else begin
            if (rk_idx > NR_IDX) rk_out <= 128'h0;
            else rk_out <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
            rk_valid <= keys_ready;
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: three scheduler instances (AES-128/192/256) checked
// against published round keys and a reference expansion computed from the
// key-schedule rules, with an S-box derived from GF(2^8) inversion.
module tb_key_sched_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        start_v;
    logic [255:0]      key_bus;
    logic [3:0]        rk_idx;
    logic [2:0]        busy_v, done_v, ready_v, valid_v;
    logic [2:0][127:0] rk_out_v;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  sbox_ref [256];
    logic [31:0] ref_w [60];
    logic        saw_valid;
    int          cyc;

    always #5 clk = ~clk;

    key_sched_ctrl #(.NK(4), .NR(10)) dut128 (
        .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key_bus[255:128]),
        .busy(busy_v[0]), .done(done_v[0]), .keys_ready(ready_v[0]),
        .rk_idx(rk_idx), .rk_out(rk_out_v[0]), .rk_valid(valid_v[0]));

    key_sched_ctrl #(.NK(6), .NR(12)) dut192 (
        .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key_bus[255:64]),
        .busy(busy_v[1]), .done(done_v[1]), .keys_ready(ready_v[1]),
        .rk_idx(rk_idx), .rk_out(rk_out_v[1]), .rk_valid(valid_v[1]));

    key_sched_ctrl #(.NK(8), .NR(14)) dut256 (
        .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key_bus),
        .busy(busy_v[2]), .done(done_v[2]), .keys_ready(ready_v[2]),
        .rk_idx(rk_idx), .rk_out(rk_out_v[2]), .rk_valid(valid_v[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_ref(input logic [31:0] x);
        return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
    endfunction

    function automatic int nk_of(input int m);
        return (m == 0) ? 4 : (m == 1) ? 6 : 8;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_ref[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                            ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic ref_expand(input int nk, input logic [255:0] key);
        int          nr;
        logic [31:0] t;
        logic [7:0]  rc;
        nr = nk + 6;
        for (int j = 0; j < nk; j++) ref_w[j] = key[255-32*j -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
                t = sub_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % 8 == 4) begin
                t = sub_ref(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_exp(input int m, input logic [255:0] key);
        ref_expand(nk_of(m), key);
        key_bus    = key;
        start_v[m] = 1'b1;
        tick();
        start_v[m] = 1'b0;
        check("capture_busy", 256'(busy_v[m]), 256'd1);
        check("capture_ready_low", 256'(ready_v[m]), 256'd0);
    endtask

    task automatic wait_done(input int m, input int exp_n, input string tag);
        int n;
        n = 0;
        saw_valid = 1'b0;
        do begin
            tick();
            n++;
            if (valid_v[m]) saw_valid = 1'b1;
        end while (!done_v[m] && n < 200);
        check(tag, 256'(n), 256'(exp_n));
    endtask

    task automatic read_all(input int m, input string tag);
        int          nr;
        logic [127:0] exp;
        nr = nk_of(m) + 6;
        for (int k = 0; k <= nr + 1; k++) begin
            rk_idx = 4'(k);
            tick();
            if (k <= nr) exp = {ref_w[4*k], ref_w[4*k+1], ref_w[4*k+2], ref_w[4*k+3]};
            else         exp = 128'h0;
            check(tag, 256'(rk_out_v[m]), 256'(exp));
            check("rk_valid", 256'(valid_v[m]), 256'd1);
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        logic [255:0] ka, kb;
        rst     = 1'b1;
        start_v = 3'b000;
        key_bus = 256'h0;
        rk_idx  = 4'd0;
        build_sbox();
        repeat (3) tick();
        check("rst_busy", 256'(busy_v), 256'd0);
        check("rst_done", 256'(done_v), 256'd0);
        check("rst_ready", 256'(ready_v), 256'd0);
        check("rst_valid", 256'(valid_v), 256'd0);
        check("rst_rk_out", 256'(rk_out_v), 256'd0);
        rst = 1'b0;
        tick();

        // AES-128 published vector
        start_exp(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        wait_done(0, 40, "aes128_latency");
        rk_idx = 4'd1;
        tick();
        check("aes128_rk1", 256'(rk_out_v[0]), 256'(128'ha0fafe1788542cb123a339392a6c7605));
        check("done_one_cycle", 256'(done_v[0]), 256'd0);
        check("first_valid", 256'(valid_v[0]), 256'd1);
        rk_idx = 4'd10;
        tick();
        check("aes128_rk10", 256'(rk_out_v[0]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        rk_idx = 4'd11;
        tick();
        check("aes128_rk11_zero", 256'(rk_out_v[0]), 256'd0);
        check("aes128_rk11_valid", 256'(valid_v[0]), 256'd1);
        read_all(0, "aes128_ref");

        // AES-192 published vector
        start_exp(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        wait_done(1, 46, "aes192_latency");
        rk_idx = 4'd12;
        tick();
        check("aes192_rk12", 256'(rk_out_v[1]), 256'(128'he98ba06f448c773c8ecc720401002202));
        read_all(1, "aes192_ref");

        // AES-256 published vector
        start_exp(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        wait_done(2, 52, "aes256_latency");
        rk_idx = 4'd14;
        tick();
        check("aes256_rk14", 256'(rk_out_v[2]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        read_all(2, "aes256_ref");

        // start pulses while busy carry a different key and must be ignored
        ka = rand_key();
        kb = rand_key();
        start_exp(0, ka);
        cyc = 0;
        do begin
            tick();
            cyc++;
            start_v[0] = (cyc == 5 || cyc == 20);
            key_bus    = (cyc == 5 || cyc == 20) ? kb : ka;
        end while (!done_v[0] && cyc < 200);
        start_v[0] = 1'b0;
        check("busy_start_latency", 256'(cyc), 256'd40);
        read_all(0, "busy_start_schedule");

        // reset in the middle of an expansion
        start_exp(0, rand_key());
        repeat (17) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 256'(busy_v[0]), 256'd0);
        check("midrst_ready", 256'(ready_v[0]), 256'd0);
        check("midrst_valid", 256'(valid_v[0]), 256'd0);
        check("midrst_done", 256'(done_v[0]), 256'd0);
        rst = 1'b0;
        tick();
        start_exp(0, rand_key());
        wait_done(0, 40, "midrst_latency");
        read_all(0, "midrst_schedule");

        // restart in the done cycle with a second key
        start_exp(0, rand_key());
        wait_done(0, 40, "restart_first_latency");
        start_exp(0, rand_key());
        check("restart_done_low", 256'(done_v[0]), 256'd0);
        wait_done(0, 40, "restart_second_latency");
        check("restart_valid_held_low", 256'(saw_valid), 256'd0);
        read_all(0, "restart_schedule");

        // random keys, every key size
        for (int m = 0; m < 3; m++) begin
            for (int r = 0; r < 2; r++) begin
                start_exp(m, rand_key());
                wait_done(m, 4*(nk_of(m)+7) - nk_of(m), "rand_latency");
                read_all(m, "rand_schedule");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
